// File: rtl/rr_operand_arbiter.sv
// Four-way round-robin operand arbiter feeding a single registered output slot.
// Optional burst locking is compiled in with `define RR_ARB_BURST_EN.
module rr_operand_arbiter #(
    parameter int WIDTH     = 16,
    parameter int BURST_LEN = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] req_data_0,
    input  logic [WIDTH-1:0] req_data_1,
    input  logic [WIDTH-1:0] req_data_2,
    input  logic [WIDTH-1:0] req_data_3,
    input  logic [3:0]       req_valid,
    output logic [3:0]       req_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             idle
);

`ifdef RR_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam int             CW       = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0]  BEAT_MAX = CW'(BURST_LEN);
    localparam logic [CW-1:0]  BEAT_ONE = CW'(1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nxt;
    logic [1:0]       r_lock;
    logic [1:0]       w_lock_nxt;
    logic [CW-1:0]    r_beat;
    logic [CW-1:0]    w_beat_nxt;

    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_src;
    logic             r_out_valid;

    logic             w_load_en;
    logic             w_locked;
    logic             w_lock_hold;
    logic [1:0]       w_base;
    logic             w_grant_vld;
    logic [1:0]       w_grant_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

    assign w_load_en   = !r_out_valid || out_ready;
    assign w_locked    = BURST && (r_state == LOCKED);
    assign w_lock_hold = w_locked && req_valid[r_lock];
    // A lock whose owner has gone quiet is released in the same cycle, so
    // the search restarts after the lock owner with no dead load cycle.
    assign w_base      = w_locked ? (r_lock + 2'd1) : r_ptr;

    always_comb begin
        logic [1:0] cand;
        cand        = w_base;
        w_grant_vld = 1'b0;
        w_grant_idx = w_base;
        if (w_lock_hold) begin
            w_grant_vld = 1'b1;
            w_grant_idx = r_lock;
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                cand = w_base + 2'(k);
                if (!w_grant_vld && req_valid[cand]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = cand;
                end
            end
        end
    end

    assign w_xfer    = w_load_en && w_grant_vld && !reset;
    assign req_ready = w_xfer ? (4'b0001 << w_grant_idx) : 4'b0000;

    always_comb begin
        w_sel_data = req_data_0;
        case (w_grant_idx)
            2'd0:    w_sel_data = req_data_0;
            2'd1:    w_sel_data = req_data_1;
            2'd2:    w_sel_data = req_data_2;
            default: w_sel_data = req_data_3;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock;
        w_beat_nxt  = r_beat;
        if (w_xfer) begin
            if (!BURST) begin
                w_ptr_nxt = w_grant_idx + 2'd1;
            end else if (w_lock_hold) begin
                if (r_beat + BEAT_ONE == BEAT_MAX) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = r_lock + 2'd1;
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt = r_beat + BEAT_ONE;
                end
            end else if (BEAT_MAX == BEAT_ONE) begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = w_grant_idx + 2'd1;
                w_beat_nxt  = '0;
            end else begin
                w_state_nxt = LOCKED;
                w_lock_nxt  = w_grant_idx;
                w_beat_nxt  = BEAT_ONE;
            end
        end else if (w_locked && w_load_en && !req_valid[r_lock]) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = r_lock + 2'd1;
            w_beat_nxt  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_lock  <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_lock  <= w_lock_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_out_data  <= w_sel_data;
            r_out_src   <= w_grant_idx;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;
    assign idle      = !r_out_valid && (req_valid == 4'b0000);

endmodule

// File: tb/tb_rr_operand_arbiter.sv
// Directed self-checking bench for rr_operand_arbiter; the burst scenario
// runs only when RR_ARB_BURST_EN is defined for the whole build.
module tb_rr_operand_arbiter;

    logic        clock;
    logic        reset;
    logic [15:0] req_data_0, req_data_1, req_data_2, req_data_3;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] out_data;
    logic [1:0]  out_src;
    logic        out_valid;
    logic        out_ready;
    logic        idle;

    int errors = 0;
    int checks = 0;

    rr_operand_arbiter #(.WIDTH(16), .BURST_LEN(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_data_0 (req_data_0),
        .req_data_1 (req_data_1),
        .req_data_2 (req_data_2),
        .req_data_3 (req_data_3),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .idle       (idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] word_of(input logic [1:0] s);
        return 16'h1111 * (16'(s) + 16'd1);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'hF;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", out_data); end
        checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_src got %0d want 0", out_src); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", idle); end
        req_valid = 4'b0000;
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_all_valid();
        do_reset();
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (req_ready !== (4'b0001 << (k % 4))) begin
                errors++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, 4'b0001 << (k % 4));
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== 2'(k % 4) || out_data !== word_of(2'(k % 4))) begin
                errors++; $display("FAIL rr_out[%0d] got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
                                   k, out_valid, out_src, out_data, k % 4, word_of(2'(k % 4)));
            end
        end
        req_valid = 4'b0000;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b want 0", out_valid); end
    endtask

    task automatic test_single_backpressure();
        do_reset();
        req_valid = 4'b0100;
        out_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_first_ready got %b want 0100", req_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h3333 || out_src !== 2'd2) begin
                errors++; $display("FAIL single_hold[%0d] got v=%b data=%h src=%0d want v=1 data=3333 src=2", k, out_valid, out_data, out_src);
            end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_stall_ready[%0d] got %b want 0000", k, req_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_resume_ready got %b want 0100", req_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_no_bubble got %b want 1", out_valid); end
        req_valid = 4'b0000;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_clear got %b want 0", out_valid); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got %b want 1", idle); end
    endtask

    task automatic test_back_to_back();
        logic       m_ov;
        logic [1:0] m_src;
        logic [1:0] m_ptr;
        logic [1:0] m_cons;
        logic       m_load;
        logic [3:0] exp_rr;
        int         consumed;
        do_reset();
        m_ov = 1'b0; m_src = 2'd0; m_ptr = 2'd0; m_cons = 2'd0; consumed = 0;
        req_valid = 4'hF;
        for (int k = 0; k < 12; k++) begin
            out_ready = (k % 2 == 0);
            #1;
            m_load = !m_ov || out_ready;
            exp_rr = m_load ? (4'b0001 << m_ptr) : 4'b0000;
            checks++;
            if (req_ready !== exp_rr) begin
                errors++; $display("FAIL bp_ready[%0d] got %b want %b", k, req_ready, exp_rr);
            end
            if (m_ov && out_ready) begin
                checks++;
                if (out_src !== m_cons) begin
                    errors++; $display("FAIL bp_consume[%0d] got src=%0d want %0d", k, out_src, m_cons);
                end
                m_cons = m_cons + 2'd1;
                consumed++;
            end
            if (m_load) begin
                m_src = m_ptr; m_ov = 1'b1; m_ptr = m_ptr + 2'd1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            tick();
            checks++;
            if (out_valid !== m_ov || out_src !== m_src || out_data !== word_of(m_src)) begin
                errors++; $display("FAIL bp_out[%0d] got v=%b src=%0d data=%h want v=%b src=%0d data=%h",
                                   k, out_valid, out_src, out_data, m_ov, m_src, word_of(m_src));
            end
        end
        checks++; if (consumed != 5) begin errors++; $display("FAIL bp_count got %0d want 5", consumed); end
        req_valid = 4'b0000;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0010;
        out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h2222) begin errors++; $display("FAIL mid_load got v=%b data=%h want v=1 data=2222", out_valid, out_data); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin errors++; $display("FAIL mid_reset got v=%b data=%h want v=0 data=0000", out_valid, out_data); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_ready got %b want 0000", req_ready); end
        req_valid = 4'hF;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_ready got %b want 0001", req_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin errors++; $display("FAIL mid_first_src got v=%b src=%0d want v=1 src=0", out_valid, out_src); end
        req_valid = 4'b0000;
        tick();
    endtask

`ifdef RR_ARB_BURST_EN
    task automatic test_burst();
        logic [1:0] exp_seq [9];
        exp_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        do_reset();
        req_valid = 4'b0011;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== exp_seq[k]) begin
                errors++; $display("FAIL burst_seq[%0d] got v=%b src=%0d want v=1 src=%0d", k, out_valid, out_src, exp_seq[k]);
            end
        end
        tick();
        checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL burst_beat2 got %0d want 0", out_src); end
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL burst_drop_ready got %b want 0010", req_ready); end
        tick();
        checks++; if (out_src !== 2'd1) begin errors++; $display("FAIL burst_drop_src got %0d want 1", out_src); end
        req_valid = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        reset      = 1'b1;
        req_valid  = 4'b0000;
        out_ready  = 1'b0;
        req_data_0 = 16'h1111;
        req_data_1 = 16'h2222;
        req_data_2 = 16'h3333;
        req_data_3 = 16'h4444;
        test_reset();
        test_all_valid();
        test_single_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef RR_ARB_BURST_EN
        test_burst();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_operand_arbiter.md
RR_OPERAND_ARBITER -- requirements
Module: rr_operand_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand data width in bits.
REQ-002 Parameter BURST_LEN, default 4, range 1..16, SHALL set the maximum beats per grant when burst mode is compiled in.
REQ-003 clock  input  1  SHALL be the rising-edge clock for all state.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 req_data_0..req_data_3  input  WIDTH each  SHALL carry operand words from requesters 0..3.
REQ-006 req_valid  input  4  SHALL mark, per bit i, that req_data_i holds a valid word.
REQ-007 req_ready  output  4  SHALL indicate, per bit i, that requester i's word is accepted this cycle.
REQ-008 out_data  output  WIDTH  SHALL carry the registered selected word.
REQ-009 out_src  output  2  SHALL carry the index of the requester that supplied out_data.
REQ-010 out_valid  output  1  SHALL mark out_data/out_src valid.
REQ-011 out_ready  input  1  SHALL indicate the downstream consumer accepts out_data this cycle.
REQ-012 idle  output  1  SHALL be high when out_valid is low and req_valid is 4'b0000.

Function
REQ-013 A requester transfer SHALL occur on a rising edge where req_valid[i] and req_ready[i] are both high; an output transfer SHALL occur where out_valid and out_ready are both high.
REQ-014 load_en SHALL be (!out_valid || out_ready); req_ready SHALL be zero whenever load_en is low.
REQ-015 When load_en is high, exactly one req_ready bit SHALL be high: the first i with req_valid[i] high, searching ptr, ptr+1, ... mod 4; req_ready SHALL be 4'b0000 if no req_valid bit is high.
REQ-016 req_ready SHALL be combinational from req_valid, ptr, state and load_en, with no dependency on req_data.
REQ-017 On a requester transfer from i, out_data SHALL load req_data_i, out_src SHALL load i, and out_valid SHALL be set at the next edge (latency 1 cycle).
REQ-018 On an output transfer with no simultaneous requester transfer, out_valid SHALL clear; with a simultaneous requester transfer, out_valid SHALL stay high and the new word SHALL replace the old one with no bubble.
REQ-019 When out_valid is high and out_ready is low, out_data and out_src SHALL hold stable.
REQ-020 Pointer ptr (2 bits) SHALL wrap 3 -> 0.
REQ-021 Without burst mode, after each requester transfer from i, ptr SHALL become (i+1) mod 4.
REQ-022 The state machine SHALL have states IDLE (no grant held) and LOCKED (grant held, burst mode only); without burst mode it SHALL remain in IDLE.
REQ-023 No word SHALL be dropped or duplicated; a requester holding valid SHALL be granted within 4 transfers in non-burst mode, or 4*BURST_LEN transfers in burst mode.

Reset
REQ-024 While reset is high, out_valid SHALL be 0, out_data SHALL be 0, out_src SHALL be 0, req_ready SHALL be 4'b0000, ptr SHALL be 0, the beat count SHALL be 0, and the state SHALL be IDLE.
REQ-025 Reset asserted mid-transfer SHALL discard the output register contents, and the first grant after reset release SHALL start the search at requester 0.

Configuration
REQ-026 Macro RR_ARB_BURST_EN, when defined, SHALL enable burst locking.
REQ-027 Burst locking: on the first transfer from requester i, the FSM SHALL enter LOCKED with lock index i and beat count 1.
REQ-028 In LOCKED, only requester i SHALL be eligible for a grant; other requesters SHALL see req_ready low.
REQ-029 In LOCKED, each transfer from i SHALL increment the beat count.
REQ-030 LOCKED SHALL return to IDLE with ptr = (i+1) mod 4 when the beat count reaches BURST_LEN, or when req_valid[i] is low while load_en is high.
REQ-031 Without RR_ARB_BURST_EN, the behaviour SHALL be per REQ-021 and BURST_LEN SHALL be ignored.

Verification
REQ-032 Reset release, all four req_valid high, out_ready held 1, data 0x1111/0x2222/0x3333/0x4444 -> out_src sequence 0,1,2,3,0,... one word per cycle, first out_valid one cycle after the first accept.
REQ-033 Only req_valid[2] high, out_ready=0 for 3 cycles then 1 -> one accept, out_data=0x3333 held 3 cycles, next accept on the cycle out_ready rises.
REQ-034 Back-pressure: out_ready toggling 1,0,1,0 with all requesters valid -> req_ready is zero on every out_ready=0 cycle with out_valid high, and there is no loss or duplication (scoreboard).
REQ-035 Reset asserted while out_valid=1 holds 0x2222 -> out_valid=0 and out_data=0 immediately, and the first post-reset grant goes to requester 0.
REQ-036 With RR_ARB_BURST_EN and BURST_LEN=4, requesters 0 and 1 continuously valid -> out_src 0,0,0,0,1,1,1,1,0...; requester 0 dropping valid after 2 beats -> grant moves to 1 on the next load cycle.
